// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// ALU operations and datapath mux selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADR   = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXEC_R    = 4'd6,
      S_EXEC_I    = 4'd7,
      S_ALU_WB    = 4'd8,
      S_JAL       = 4'd9,
      S_JALR      = 4'd10,
      S_JALR_LINK = 4'd11,
      S_BRANCH    = 4'd12,
      S_LUI       = 4'd13,
      S_AUIPC     = 4'd14,
      S_HALT      = 4'd15
   } state_t;

   localparam logic [6:0] OPC_LOAD   = 7'h03;
   localparam logic [6:0] OPC_FENCE  = 7'h0F;
   localparam logic [6:0] OPC_OP_IMM = 7'h13;
   localparam logic [6:0] OPC_AUIPC  = 7'h17;
   localparam logic [6:0] OPC_STORE  = 7'h23;
   localparam logic [6:0] OPC_OP     = 7'h33;
   localparam logic [6:0] OPC_LUI    = 7'h37;
   localparam logic [6:0] OPC_BRANCH = 7'h63;
   localparam logic [6:0] OPC_JALR   = 7'h67;
   localparam logic [6:0] OPC_JAL    = 7'h6F;
   localparam logic [6:0] OPC_SYSTEM = 7'h73;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_AND    = 4'd2;
   localparam logic [3:0] ALU_OR     = 4'd3;
   localparam logic [3:0] ALU_XOR    = 4'd4;
   localparam logic [3:0] ALU_SLL    = 4'd5;
   localparam logic [3:0] ALU_SRL    = 4'd6;
   localparam logic [3:0] ALU_SRA    = 4'd7;
   localparam logic [3:0] ALU_SLT    = 4'd8;
   localparam logic [3:0] ALU_SLTU   = 4'd9;
   localparam logic [3:0] ALU_PASS_B = 4'd10;

   localparam logic [2:0] IMM_I = 3'd0;
   localparam logic [2:0] IMM_S = 3'd1;
   localparam logic [2:0] IMM_B = 3'd2;
   localparam logic [2:0] IMM_U = 3'd3;
   localparam logic [2:0] IMM_J = 3'd4;

   localparam logic [1:0] SRC_A_OLD_PC = 2'd0;
   localparam logic [1:0] SRC_A_PC     = 2'd1;
   localparam logic [1:0] SRC_A_REG    = 2'd2;

   localparam logic [1:0] SRC_B_REG  = 2'd0;
   localparam logic [1:0] SRC_B_IMM  = 2'd1;
   localparam logic [1:0] SRC_B_FOUR = 2'd2;

   localparam logic [2:0] OUT_ALU_REG  = 3'd0;
   localparam logic [2:0] OUT_ALU_OUT  = 3'd1;
   localparam logic [2:0] OUT_DATA_REG = 3'd2;

   localparam logic [1:0] MEM_BYTE = 2'd0;
   localparam logic [1:0] MEM_HALF = 2'd1;
   localparam logic [1:0] MEM_WORD = 2'd2;

   // Only base (0x00) and alternate (0x20) R-type encodings are implemented.
   function automatic logic funct7_legal(input logic [6:0] f7);
      return (f7 == 7'h00) || (f7 == 7'h20);
   endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps funct3/funct7[5] to the ALU operation for register and immediate ALU ops.
module alu_decoder
   import ctrl_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7_5,
   input  logic       is_op_imm,
   output logic [3:0] alu_ctrl
);

   always_comb begin
      alu_ctrl = ALU_ADD;
      case (funct3)
         3'b000:  alu_ctrl = (funct7_5 && !is_op_imm) ? ALU_SUB : ALU_ADD; // ADDI has no SUB form
         3'b001:  alu_ctrl = ALU_SLL;
         3'b010:  alu_ctrl = ALU_SLT;
         3'b011:  alu_ctrl = ALU_SLTU;
         3'b100:  alu_ctrl = ALU_XOR;
         3'b101:  alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
         3'b110:  alu_ctrl = ALU_OR;
         3'b111:  alu_ctrl = ALU_AND;
         default: alu_ctrl = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Moore main control FSM for the multicycle RV32I core, one instruction phase
// per cycle, plus a retired-instruction counter and halt flag.
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [6:0]           opcode,
   input  logic [2:0]           funct3,
   input  logic [6:0]           funct7,
   input  logic                 zero_flag,
   input  logic                 alu_lt,
   output logic                 adr_src,
   output logic                 pc_write,
   output logic                 ir_write,
   output logic                 mem_write,
   output logic                 reg_write,
   output logic                 output_en,
   output logic [1:0]           mem_ctrl,
   output logic [2:0]           out_mux_sel,
   output logic [2:0]           imm_extend_sel,
   output logic [2:0]           load_extend_sel,
   output logic [1:0]           alu_src_a_sel,
   output logic [1:0]           alu_src_b_sel,
   output logic [3:0]           alu_ctrl,
   output logic [3:0]           state,
   output logic                 halted,
   output logic                 instr_retired,
   output logic [CNT_WIDTH-1:0] instret_count
);

   state_t     cur, nxt;
   logic [3:0] dec_alu;
   logic       pc_wr_raw, ir_wr_raw, mem_wr_raw, reg_wr_raw;

   alu_decoder u_alu_dec (
      .funct3   (funct3),
      .funct7_5 (funct7[5]),
      .is_op_imm(cur == S_EXEC_I),
      .alu_ctrl (dec_alu)
   );

   always_ff @(posedge clk) begin
      if (rst) cur <= S_FETCH;
      else     cur <= nxt;
   end

   always_ff @(posedge clk) begin
      if (rst)                instret_count <= '0;
      else if (instr_retired) instret_count <= instret_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   end

   always_comb begin
      nxt             = cur;
      adr_src         = 1'b0;
      pc_wr_raw       = 1'b0;
      ir_wr_raw       = 1'b0;
      mem_wr_raw      = 1'b0;
      reg_wr_raw      = 1'b0;
      mem_ctrl        = MEM_BYTE;
      out_mux_sel     = OUT_ALU_REG;
      imm_extend_sel  = IMM_I;
      load_extend_sel = 3'd0;
      alu_src_a_sel   = SRC_A_OLD_PC;
      alu_src_b_sel   = SRC_B_REG;
      alu_ctrl        = ALU_ADD;
      halted          = 1'b0;
      case (cur)
         S_FETCH: begin
            ir_wr_raw     = 1'b1;
            pc_wr_raw     = 1'b1;
            alu_src_a_sel = SRC_A_PC;
            alu_src_b_sel = SRC_B_FOUR;
            out_mux_sel   = OUT_ALU_OUT;
            nxt           = S_DECODE;
         end
         S_DECODE: begin
            // Precompute the JAL/branch target into alu_reg while decoding.
            alu_src_b_sel  = SRC_B_IMM;
            imm_extend_sel = (opcode == OPC_JAL) ? IMM_J : IMM_B;
            case (opcode)
               OPC_LOAD, OPC_STORE: nxt = S_MEM_ADR;
               OPC_OP:              nxt = funct7_legal(funct7) ? S_EXEC_R : S_HALT;
               OPC_OP_IMM:          nxt = S_EXEC_I;
               OPC_BRANCH:          nxt = S_BRANCH;
               OPC_JAL:             nxt = S_JAL;
               OPC_JALR:            nxt = S_JALR;
               OPC_LUI:             nxt = S_LUI;
               OPC_AUIPC:           nxt = S_AUIPC;
               OPC_FENCE:           nxt = S_FETCH;
               default:             nxt = S_HALT;
            endcase
         end
         S_MEM_ADR: begin
            alu_src_a_sel  = SRC_A_REG;
            alu_src_b_sel  = SRC_B_IMM;
            imm_extend_sel = (opcode == OPC_STORE) ? IMM_S : IMM_I;
            nxt            = (opcode == OPC_STORE) ? S_MEM_WRITE : S_MEM_READ;
         end
         S_MEM_READ: begin
            adr_src         = 1'b1;
            load_extend_sel = funct3;
            nxt             = S_MEM_WB;
         end
         S_MEM_WB: begin
            out_mux_sel = OUT_DATA_REG;
            reg_wr_raw  = 1'b1;
            nxt         = S_FETCH;
         end
         S_MEM_WRITE: begin
            adr_src    = 1'b1;
            mem_wr_raw = 1'b1;
            mem_ctrl   = funct3[1:0];
            nxt        = S_FETCH;
         end
         S_EXEC_R: begin
            alu_src_a_sel = SRC_A_REG;
            alu_ctrl      = dec_alu;
            nxt           = S_ALU_WB;
         end
         S_EXEC_I: begin
            alu_src_a_sel = SRC_A_REG;
            alu_src_b_sel = SRC_B_IMM;
            alu_ctrl      = dec_alu;
            nxt           = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_wr_raw = 1'b1;
            nxt        = S_FETCH;
         end
         S_JAL: begin
            pc_wr_raw     = 1'b1;
            alu_src_b_sel = SRC_B_FOUR;
            nxt           = S_ALU_WB;
         end
         S_JALR: begin
            alu_src_a_sel = SRC_A_REG;
            alu_src_b_sel = SRC_B_IMM;
            out_mux_sel   = OUT_ALU_OUT;
            pc_wr_raw     = 1'b1;
            nxt           = S_JALR_LINK;
         end
         S_JALR_LINK: begin
            alu_src_b_sel = SRC_B_FOUR;
            out_mux_sel   = OUT_ALU_OUT;
            reg_wr_raw    = 1'b1;
            nxt           = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a_sel = SRC_A_REG;
            case (funct3)
               3'b000:  begin alu_ctrl = ALU_SUB;  pc_wr_raw = zero_flag;  end
               3'b001:  begin alu_ctrl = ALU_SUB;  pc_wr_raw = !zero_flag; end
               3'b100:  begin alu_ctrl = ALU_SLT;  pc_wr_raw = alu_lt;     end
               3'b101:  begin alu_ctrl = ALU_SLT;  pc_wr_raw = !alu_lt;    end
               3'b110:  begin alu_ctrl = ALU_SLTU; pc_wr_raw = alu_lt;     end
               3'b111:  begin alu_ctrl = ALU_SLTU; pc_wr_raw = !alu_lt;    end
               default: begin alu_ctrl = ALU_ADD;  pc_wr_raw = 1'b0;       end
            endcase
            nxt = S_FETCH;
         end
         S_LUI: begin
            alu_src_b_sel  = SRC_B_IMM;
            imm_extend_sel = IMM_U;
            alu_ctrl       = ALU_PASS_B;
            out_mux_sel    = OUT_ALU_OUT;
            reg_wr_raw     = 1'b1;
            nxt            = S_FETCH;
         end
         S_AUIPC: begin
            alu_src_b_sel  = SRC_B_IMM;
            imm_extend_sel = IMM_U;
            out_mux_sel    = OUT_ALU_OUT;
            reg_wr_raw     = 1'b1;
            nxt            = S_FETCH;
         end
         S_HALT: begin
            halted = 1'b1;
            nxt    = S_HALT;
         end
         default: nxt = S_HALT;
      endcase
   end

   // Reset suppresses every write so an interrupted instruction leaves no trace.
   assign pc_write      = pc_wr_raw  & ~rst;
   assign ir_write      = ir_wr_raw  & ~rst;
   assign mem_write     = mem_wr_raw & ~rst;
   assign reg_write     = reg_wr_raw & ~rst;
   assign output_en     = reg_write;
   assign instr_retired = (nxt == S_FETCH) && (cur != S_FETCH) && !rst;
   assign state         = cur;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state traces, strobes, retire counting.
module tb_multicycle_control;

   logic        clk = 1'b0;
   logic        rst;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic        zero_flag, alu_lt;
   logic        adr_src, pc_write, ir_write, mem_write, reg_write, output_en;
   logic [1:0]  mem_ctrl, alu_src_a_sel, alu_src_b_sel;
   logic [2:0]  out_mux_sel, imm_extend_sel, load_extend_sel;
   logic [3:0]  alu_ctrl, state;
   logic        halted, instr_retired;
   logic [31:0] instret_count;

   int errors = 0;
   int checks = 0;

   multicycle_control #(.CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .zero_flag(zero_flag), .alu_lt(alu_lt), .adr_src(adr_src), .pc_write(pc_write),
      .ir_write(ir_write), .mem_write(mem_write), .reg_write(reg_write),
      .output_en(output_en), .mem_ctrl(mem_ctrl), .out_mux_sel(out_mux_sel),
      .imm_extend_sel(imm_extend_sel), .load_extend_sel(load_extend_sel),
      .alu_src_a_sel(alu_src_a_sel), .alu_src_b_sel(alu_src_b_sel),
      .alu_ctrl(alu_ctrl), .state(state), .halted(halted),
      .instr_retired(instr_retired), .instret_count(instret_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; opcode = 7'h33; funct3 = 3'd0; funct7 = 7'h00; zero_flag = 1'b0; alu_lt = 1'b0;
      tick(); tick();
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
      checks++; if (instret_count !== 32'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", instret_count); end
      rst = 1'b0;
      tick(); tick();
      checks++; if (state !== 4'd6) begin errors++; $display("FAIL pre_reset_exec_r: got %0d want 6", state); end
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         checks++;
         if ({adr_src, pc_write, ir_write, mem_write, reg_write, output_en, instr_retired} !== 7'b0)
            begin errors++; $display("FAIL reset_strobes cyc%0d: got %b want 0", c, {adr_src, pc_write, ir_write, mem_write, reg_write, output_en, instr_retired}); end
      end
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_abort_state: got %0d want 0", state); end
      checks++; if (instret_count !== 32'd0) begin errors++; $display("FAIL reset_abort_count: got %0d want 0", instret_count); end
      rst = 1'b0;
      #1;
      checks++; if ({ir_write, pc_write} !== 2'b11) begin errors++; $display("FAIL fetch_after_reset: got %b want 11", {ir_write, pc_write}); end
   endtask

   task automatic test_add();
      logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
      int ret = 0;
      opcode = 7'h33; funct3 = 3'd0; funct7 = 7'h00;
      for (int c = 0; c < 4; c++) begin
         checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL add_state cyc%0d: got %0d want %0d", c, state, exp_st[c]); end
         checks++; if ({reg_write, output_en} !== {2{c == 3}}) begin errors++; $display("FAIL add_reg_write cyc%0d: got %b", c, {reg_write, output_en}); end
         if (c == 0) begin
            checks++;
            if ({alu_src_a_sel, alu_src_b_sel, out_mux_sel, adr_src} !== {2'd1, 2'd2, 3'd1, 1'b0})
               begin errors++; $display("FAIL fetch_sels: got %b want 011000010", {alu_src_a_sel, alu_src_b_sel, out_mux_sel, adr_src}); end
         end
         if (c == 1) begin
            checks++;
            if ({alu_src_a_sel, alu_src_b_sel, imm_extend_sel} !== {2'd0, 2'd1, 3'd2})
               begin errors++; $display("FAIL decode_sels: got %b want 0001010", {alu_src_a_sel, alu_src_b_sel, imm_extend_sel}); end
         end
         if (c == 2) begin
            checks++; if (alu_ctrl !== 4'd0) begin errors++; $display("FAIL add_alu_ctrl: got %0d want 0", alu_ctrl); end
         end
         ret += int'(instr_retired);
         tick();
      end
      checks++; if (ret !== 1) begin errors++; $display("FAIL add_retire_pulses: got %0d want 1", ret); end
      checks++; if (instret_count !== 32'd1) begin errors++; $display("FAIL add_count: got %0d want 1", instret_count); end
   endtask

   task automatic test_lw();
      logic [3:0] exp_st [5] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4};
      opcode = 7'h03; funct3 = 3'b010; funct7 = 7'h00;
      for (int c = 0; c < 5; c++) begin
         checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL lw_state cyc%0d: got %0d want %0d", c, state, exp_st[c]); end
         if (c == 2) begin
            checks++;
            if ({alu_src_a_sel, alu_src_b_sel, imm_extend_sel} !== {2'd2, 2'd1, 3'd0})
               begin errors++; $display("FAIL lw_mem_adr: got %b want 1001000", {alu_src_a_sel, alu_src_b_sel, imm_extend_sel}); end
         end
         if (c == 3) begin
            checks++;
            if ({adr_src, load_extend_sel, reg_write} !== {1'b1, 3'd2, 1'b0})
               begin errors++; $display("FAIL lw_mem_read: got %b want 10100", {adr_src, load_extend_sel, reg_write}); end
         end
         if (c == 4) begin
            checks++;
            if ({out_mux_sel, reg_write, instr_retired} !== {3'd2, 1'b1, 1'b1})
               begin errors++; $display("FAIL lw_mem_wb: got %b want 01011", {out_mux_sel, reg_write, instr_retired}); end
         end
         tick();
      end
      checks++; if (state !== 4'd0) begin errors++; $display("FAIL lw_end_state: got %0d want 0", state); end
      checks++; if (instret_count !== 32'd2) begin errors++; $display("FAIL lw_count: got %0d want 2", instret_count); end
   endtask

   task automatic test_sb();
      logic [3:0] exp_st [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
      int writes = 0;
      int regw = 0;
      opcode = 7'h23; funct3 = 3'b000; funct7 = 7'h00;
      for (int c = 0; c < 4; c++) begin
         checks++; if (state !== exp_st[c]) begin errors++; $display("FAIL sb_state cyc%0d: got %0d want %0d", c, state, exp_st[c]); end
         if (c == 2) begin
            checks++; if (imm_extend_sel !== 3'd1) begin errors++; $display("FAIL sb_imm_sel: got %0d want 1", imm_extend_sel); end
         end
         if (mem_write) begin
            writes++;
            checks++; if ({mem_ctrl, adr_src} !== {2'd0, 1'b1}) begin errors++; $display("FAIL sb_mem_ctrl: got %b want 001", {mem_ctrl, adr_src}); end
         end
         regw += int'(reg_write);
         tick();
      end
      checks++; if (writes !== 1) begin errors++; $display("FAIL sb_write_cycles: got %0d want 1", writes); end
      checks++; if (regw !== 0) begin errors++; $display("FAIL sb_reg_write: got %0d want 0", regw); end
      checks++; if (instret_count !== 32'd3) begin errors++; $display("FAIL sb_count: got %0d want 3", instret_count); end
   endtask

   task automatic test_branch();
      // {funct3, zero_flag, alu_lt, expected alu_ctrl, expected pc_write}
      logic [9:0] vec [3] = '{{3'b001, 1'b1, 1'b0, 4'd1, 1'b0},
                              {3'b110, 1'b0, 1'b1, 4'd9, 1'b1},
                              {3'b010, 1'b1, 1'b1, 4'd0, 1'b0}};
      opcode = 7'h63; funct7 = 7'h00;
      for (int v = 0; v < 3; v++) begin
         funct3 = vec[v][9:7]; zero_flag = vec[v][6]; alu_lt = vec[v][5];
         tick(); tick();
         checks++; if (state !== 4'd12) begin errors++; $display("FAIL br%0d_state: got %0d want 12", v, state); end
         checks++;
         if ({alu_ctrl, pc_write, instr_retired} !== {vec[v][4:0], 1'b1})
            begin errors++; $display("FAIL br%0d_ctrl: got %b want %b", v, {alu_ctrl, pc_write, instr_retired}, {vec[v][4:0], 1'b1}); end
         tick();
      end
      zero_flag = 1'b0; alu_lt = 1'b0;
      checks++; if (instret_count !== 32'd6) begin errors++; $display("FAIL br_count: got %0d want 6", instret_count); end
   endtask

   task automatic test_jal_fence_lui();
      opcode = 7'h6F; funct3 = 3'd0;
      tick();
      checks++; if (imm_extend_sel !== 3'd4) begin errors++; $display("FAIL jal_decode_imm: got %0d want 4", imm_extend_sel); end
      tick();
      checks++;
      if ({state, pc_write, alu_src_a_sel, alu_src_b_sel, out_mux_sel, reg_write} !== {4'd9, 1'b1, 2'd0, 2'd2, 3'd0, 1'b0})
         begin errors++; $display("FAIL jal_state: got %b", {state, pc_write, alu_src_a_sel, alu_src_b_sel, out_mux_sel, reg_write}); end
      tick();
      checks++; if ({state, reg_write} !== {4'd8, 1'b1}) begin errors++; $display("FAIL jal_wb: got %b want 10001", {state, reg_write}); end
      tick();
      opcode = 7'h0F;
      tick();
      checks++; if ({state, instr_retired} !== {4'd1, 1'b1}) begin errors++; $display("FAIL fence_retire: got %b want 00011", {state, instr_retired}); end
      tick();
      opcode = 7'h37;
      tick(); tick();
      checks++;
      if ({state, alu_ctrl, imm_extend_sel, alu_src_b_sel, out_mux_sel, reg_write} !== {4'd13, 4'd10, 3'd3, 2'd1, 3'd1, 1'b1})
         begin errors++; $display("FAIL lui_ctrl: got %b", {state, alu_ctrl, imm_extend_sel, alu_src_b_sel, out_mux_sel, reg_write}); end
      tick();
      checks++; if (instret_count !== 32'd9) begin errors++; $display("FAIL jfl_count: got %0d want 9", instret_count); end
   endtask

   task automatic test_halt();
      opcode = 7'h73; funct3 = 3'd0;
      tick(); tick();
      for (int c = 0; c < 10; c++) begin
         checks++;
         if ({state, halted, adr_src, pc_write, ir_write, mem_write, reg_write, instr_retired} !== {4'd15, 1'b1, 6'b0})
            begin errors++; $display("FAIL halt cyc%0d: got %b", c, {state, halted, adr_src, pc_write, ir_write, mem_write, reg_write, instr_retired}); end
         tick();
      end
      checks++; if (instret_count !== 32'd9) begin errors++; $display("FAIL halt_count: got %0d want 9", instret_count); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if ({state, halted, instret_count} !== {4'd0, 1'b0, 32'd0}) begin errors++; $display("FAIL halt_exit: state %0d halted %b count %0d", state, halted, instret_count); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sb();
      test_branch();
      test_jal_fence_lui();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle RV32I core.
- Consumes opcode/funct3/funct7/zero_flag/alu_lt from the datapath.
- Drives every datapath select and write-enable, one instruction phase per cycle.
- Also keeps a retired-instruction counter and a halt flag for bench and debug visibility.

Parameters:
CNT_WIDTH, 32, width of instret_count.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
opcode  input  7  inst[6:0]
funct3  input  3  inst[14:12]
funct7  input  7  inst[31:25]
zero_flag  input  1  ALU result == 0
alu_lt  input  1  ALU compare result for the selected SLT/SLTU op
adr_src, pc_write, ir_write, mem_write, reg_write, output_en  output  1 each  datapath strobes/selects
mem_ctrl  output  2  0 byte, 1 half, 2 word
out_mux_sel  output  3  0 alu_reg, 1 alu_out, 2 data_reg
imm_extend_sel  output  3  0 I, 1 S, 2 B, 3 U, 4 J
load_extend_sel  output  3  funct3 passthrough
alu_src_a_sel  output  2  0 old PC, 1 PC, 2 a_reg
alu_src_b_sel  output  2  0 b_reg, 1 imm, 2 const 4
alu_ctrl  output  4  package encoding
state  output  4  current state, for debug
halted  output  1  high in HALT
instr_retired  output  1  one-cycle pulse on the last cycle of each instruction
instret_count  output  CNT_WIDTH  retired-instruction count, wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset: while rst=1, all strobes are forced to 0, instr_retired=0 and instret_count=0; the next state is FETCH. Reset mid-instruction aborts the instruction with no writes.
- Outputs are combinational from state, opcode and funct fields. All strobes not listed for a state are 0.
- Any output not listed for a state is 0.
- output_en equals reg_write.
- FETCH: adr_src=0, ir_write=1, a=1, b=2, ADD, out_mux=1, pc_write=1. Next state: DECODE.
- DECODE: a=0, b=1, ADD; imm=J if opcode is JAL, else B. This latches the JAL/branch target into alu_reg. Next state by opcode:
  - LOAD/STORE -> MEM_ADR
  - OP -> EXEC_R, or HALT if funct7 is not 0x00/0x20
  - OP_IMM -> EXEC_I
  - BRANCH -> BRANCH
  - JAL -> JAL
  - JALR -> JALR
  - LUI -> LUI
  - AUIPC -> AUIPC
  - FENCE -> FETCH (retires)
  - SYSTEM or unknown -> HALT
- MEM_ADR: a=2, b=1, imm=I for load / S for store, ADD. Next: MEM_READ or MEM_WRITE.
- MEM_READ: adr_src=1, out_mux=0, load_extend_sel=funct3. Next: MEM_WB.
- MEM_WB: out_mux=2, reg_write=1. Next: FETCH.
- MEM_WRITE: adr_src=1, out_mux=0, mem_write=1, mem_ctrl=funct3[1:0]. Next: FETCH.
- EXEC_R: a=2, b=0, alu_ctrl from funct3 plus funct7[5]. Next: ALU_WB.
- EXEC_I: a=2, b=1, imm I. funct3=000 always ADD; 101 uses funct7[5] for SRA. Next: ALU_WB.
- ALU_WB: out_mux=0, reg_write=1. Next: FETCH.
- JAL: out_mux=0, pc_write=1, a=0, b=2, ADD (link value into alu_reg). Next: ALU_WB.
- JALR: a=2, b=1, imm I, ADD, out_mux=1, pc_write=1. Target bit0 is not cleared. Next: JALR_LINK.
- JALR_LINK: a=0, b=2, ADD, out_mux=1, reg_write=1. Next: FETCH.
- BRANCH: a=2, b=0, out_mux=0.
  - alu_ctrl: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
  - pc_write = taken: zero, !zero, lt, !lt, lt, !lt respectively.
  - funct3 010/011: not taken.
  - Next: FETCH.
- LUI: b=1, imm U, PASS_B, out_mux=1, reg_write=1. Next: FETCH.
- AUIPC: a=0, b=1, imm U, ADD, out_mux=1, reg_write=1. Next: FETCH.
- HALT: all strobes 0, halted=1. Exits only via rst.
- instr_retired=1 in every state whose next state is FETCH, excluding FETCH itself. instret_count increments on that cycle.
- Latencies in cycles: load 5; store, R, I, JAL, JALR 4; branch, LUI, AUIPC 3; FENCE 2.

Decomposition:
- Package ctrl_pkg holds:
  - state enum
  - opcode constants
  - ALU encoding: ADD0 SUB1 AND2 OR3 XOR4 SLL5 SRL6 SRA7 SLT8 SLTU9 PASS_B10
  - imm_sel, mux-select and mem_ctrl constants
- One combinational sub-module alu_decoder maps (funct3, funct7[5], is_op_imm) to alu_ctrl.

Test Plan:
- Reset held 3 cycles mid-EXEC_R -> state=FETCH, all strobes 0 during reset, instret_count=0.
- ADD (opcode 0x33, funct7 0x00) -> state trace FETCH, DECODE, EXEC_R, ALU_WB; alu_ctrl=0 in EXEC_R; reg_write only in ALU_WB; one retire pulse.
- LW (0x03, funct3 010) -> 5 cycles; adr_src=1 in MEM_READ; load_extend_sel=2; out_mux=2 with reg_write in MEM_WB.
- SB (0x23, funct3 000) -> mem_write=1, mem_ctrl=0 in exactly one cycle; reg_write never asserted.
- BNE with zero_flag=1 -> pc_write=0 in BRANCH. BLTU with alu_lt=1 -> alu_ctrl=9, pc_write=1.
- ECALL (0x73) -> HALT after DECODE; halted=1 held 10 cycles with no strobes; rst returns to FETCH.
